// File: rtl/ca5_q2.sv
// Moore detector for the overlapping serial pattern 1-0-0-1.
// w is registered and pulses for one cycle after each match.
module ca5_q2 (
  input  logic clk,
  input  logic rst,
  input  logic j,
  output logic w
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_w;

  always_comb begin
    w_next = S0;
    case (r_state)
      S0: w_next = j ? S1 : S0;
      S1: w_next = j ? S1 : S2;
      S2: w_next = j ? S1 : S3;
      S3: w_next = j ? S4 : S0;
      S4: w_next = j ? S1 : S2;
      default: w_next = S0;
    endcase
  end

  // w tracks the state register, so it equals (r_state == S4)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S0;
      r_w     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_w     <= (w_next == S4);
    end
  end

  assign w = r_w;

endmodule

// File: tb/tb_ca5_q2.sv
// Directed bench for the 1001 sequence detector.
// Drives j on falling edges, checks w 1ns after rising edges.
module tb_ca5_q2;

  logic clk;
  logic rst;
  logic j;
  logic w;

  int checks;
  int errors;

  ca5_q2 dut (
    .clk (clk),
    .rst (rst),
    .j   (j),
    .w   (w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic exp);
    checks++;
    assert (w === exp)
    else begin
      errors++;
      $error("FAIL %s: w=%b expected %b", tag, w, exp);
    end
  endtask

  task automatic step(input string tag,
                      input logic jv,
                      input logic exp);
    @(negedge clk);
    j = jv;
    @(posedge clk);
    #1;
    chk(tag, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_hold", 1'b0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    j = 1'b0;

    // reset held with j toggling
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      j = ~j;
      @(posedge clk);
      #1;
      chk("reset_w0", 1'b0);
    end
    @(negedge clk);
    rst = 1'b1;

    // basic match
    step("basic1", 1'b1, 1'b0);
    step("basic2", 1'b0, 1'b0);
    step("basic3", 1'b0, 1'b0);
    step("basic4", 1'b1, 1'b1);
    step("basic5", 1'b0, 1'b0);

    // full stream 1100100101
    do_reset();
    step("full1",  1'b1, 1'b0);
    step("full2",  1'b1, 1'b0);
    step("full3",  1'b0, 1'b0);
    step("full4",  1'b0, 1'b0);
    step("full5",  1'b1, 1'b1);
    step("full6",  1'b0, 1'b0);
    step("full7",  1'b0, 1'b0);
    step("full8",  1'b1, 1'b1);
    step("full9",  1'b0, 1'b0);
    step("full10", 1'b1, 1'b0);

    // near misses 1010001, then 001 proves S1
    do_reset();
    step("near1", 1'b1, 1'b0);
    step("near2", 1'b0, 1'b0);
    step("near3", 1'b1, 1'b0);
    step("near4", 1'b0, 1'b0);
    step("near5", 1'b0, 1'b0);
    step("near6", 1'b0, 1'b0);
    step("near7", 1'b1, 1'b0);
    step("near8", 1'b0, 1'b0);
    step("near9", 1'b0, 1'b0);
    step("near10", 1'b1, 1'b1);

    // async reset while w is high
    #1;
    rst = 1'b0;
    #1;
    chk("async_clr", 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // reset pulse mid-pattern aborts prefix
    step("mid1", 1'b1, 1'b0);
    step("mid2", 1'b0, 1'b0);
    step("mid3", 1'b0, 1'b0);
    @(negedge clk);
    j = 1'b1;
    rst = 1'b0;
    #1;
    chk("mid_rst", 1'b0);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid4", 1'b0);
    step("mid5", 1'b0, 1'b0);
    step("mid6", 1'b0, 1'b0);
    step("mid7", 1'b1, 1'b1);

    // j glitch between edges is ignored
    do_reset();
    step("gl1", 1'b1, 1'b0);
    step("gl2", 1'b0, 1'b0);
    @(negedge clk);
    j = 1'b1;
    #2;
    j = 1'b0;
    @(posedge clk);
    #1;
    chk("gl3", 1'b0);
    step("gl4", 1'b1, 1'b1);

    // back-to-back overlap 1001001001
    do_reset();
    step("b2b1",  1'b1, 1'b0);
    step("b2b2",  1'b0, 1'b0);
    step("b2b3",  1'b0, 1'b0);
    step("b2b4",  1'b1, 1'b1);
    step("b2b5",  1'b0, 1'b0);
    step("b2b6",  1'b0, 1'b0);
    step("b2b7",  1'b1, 1'b1);
    step("b2b8",  1'b0, 1'b0);
    step("b2b9",  1'b0, 1'b0);
    step("b2b10", 1'b1, 1'b1);
    step("b2b11", 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ca5_q2.md
Name: ca5_q2

Overview:
- Single-input, single-output synchronous sequence detector, built as a Moore FSM.
- Watches serial bit stream j, one bit per rising clk edge.
- Asserts w for exactly one clock cycle after the overlapping pattern 1-0-0-1 has been received.
- Used as a standalone control/monitor leaf block.

Parameters:
- none (pattern fixed to 1001; state encoding is an implementation choice, 3-bit binary recommended)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset (rst=0 forces reset immediately, independent of clk)
- j    input  1  serial data bit, sampled on rising clk edge
- w    output 1  detection flag; high for one cycle when the last four sampled bits were 1,0,0,1

Behaviour:
- One clock; reset is asynchronous and active-low.
- While rst=0: state=S0, w=0, regardless of clk or j. Normal operation resumes on the first rising clk edge after rst returns to 1.
- States (Moore, w decoded from state only):
  - S0: no useful prefix; w=0
  - S1: "1" seen; w=0
  - S2: "10" seen; w=0
  - S3: "100" seen; w=0
  - S4: "1001" seen; w=1
- Transitions on rising clk, given j:
  - S0: j=1 -> S1; j=0 -> S0
  - S1: j=1 -> S1; j=0 -> S2
  - S2: j=1 -> S1; j=0 -> S3
  - S3: j=1 -> S4; j=0 -> S0
  - S4: j=1 -> S1; j=0 -> S2 (overlap: the final 1 starts a new match)
- Latency:
  - w rises right after the edge that samples the final 1 of the pattern, and stays high for exactly one clock period.
  - w cannot stay high for two consecutive cycles, because consecutive matches are at least 3 bits apart.
- Overlap: "1001001" yields two pulses (bits 1-4 and 4-7).
- Output glitch-free: w is driven from the registered state, with no combinational path from j to w.
- Unused encodings (if any) must go to S0 on the next edge with w=0.
- Reset mid-match (e.g. in S3) discards the prefix; a subsequent "1" restarts at S1.
- j changes between edges have no effect; only the value at the rising edge matters.

Test Plan:
- Reset: hold rst=0 for 3 clk cycles with j toggling -> w=0 and state=S0 throughout; after rst=1, first j=1 edge -> S1.
- Basic match: j = 1,0,0,1 on four consecutive edges -> w=1 for exactly the cycle after the 4th edge, then 0.
- Full stream: after reset release, j = 1,1,0,0,1,0,0,1,0,1 on edges 1..10 -> w=1 only after edges 5 and 8, w=0 elsewhere (state after edge 10 = S1).
- Near misses: j = 1,0,1,0,0,0,1 -> w never asserts ("101" returns to S1; "1000" returns to S0).
- Async reset mid-pattern: j = 1,0,0, then pulse rst=0 between edges, then j=1 -> w stays 0 (pattern aborted), next S1.
- Back-to-back overlap: j = 1,0,0,1,0,0,1,0,0,1 -> three single-cycle w pulses, after edges 4, 7 and 10.
